seq_signed_div: RTL and testbench

- Multi-cycle signed integer divider; the inverse of the team's combinational Booth multiplier.
- Takes a WIDTH-bit signed dividend and divisor. Produces quotient and remainder such that dividend = quotient*divisor + remainder.
- Uses a restoring shift-subtract datapath on magnitudes, one quotient bit per clock, behind a start/busy/done handshake.
- Sits in the arithmetic datapath next to the multiplier, where area matters more than latency.

---
 rtl/arith_pkg.sv | 37 +++
 rtl/seq_signed_div_if.sv | 26 ++
 rtl/div_step.sv | 26 ++
 rtl/seq_signed_div.sv | 137 +++++++++++++
 tb/tb_seq_signed_div.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Arithmetic helpers shared by the sequential signed divider.
//   state_t   - divider control states
//   negate    - two's-complement negate, result masked to w bits
//   magnitude - |v| of a w-bit two's-complement value, w+1 bits wide
//   min_val   - most-negative w-bit value (bit w-1 set)
// All helpers work on a 33-bit carrier so one copy serves every width 4..32.
package arith_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    typedef logic [MAX_W:0] wide_t;

    function automatic wide_t width_mask(input int unsigned w);
        return (wide_t'(1) << w) - wide_t'(1);
    endfunction

    function automatic wide_t negate(input wide_t v, input int unsigned w);
        return (~v + wide_t'(1)) & width_mask(w);
    endfunction

    // Sign-extend before negating so |most-negative| comes out as 2^(w-1)
    // in w+1 bits instead of aliasing back to itself.
    function automatic wide_t magnitude(input wide_t v, input int unsigned w);
        wide_t s;
        s = v >> (w - 1);
        if (s[0])
            return negate(v | ~width_mask(w), w + 1);
        return v & width_mask(w);
    endfunction

    function automatic wide_t min_val(input int unsigned w);
        return wide_t'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/seq_signed_div_if.sv
// Request/response bundle for seq_signed_div.
//   master: drives start/dividend/divisor, observes results and status
//   slave : the divider
interface seq_signed_div_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   prem      : current partial remainder (WIDTH+1 bits, always < dmag)
//   bit_in    : next dividend bit shifted into the remainder
//   dmag      : divisor magnitude (WIDTH+1 bits)
//   prem_next : partial remainder after the trial subtract / restore
//   q_bit     : quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] prem,
    input  logic           bit_in,
    input  logic [WIDTH:0] dmag,
    output logic [WIDTH:0] prem_next,
    output logic           q_bit
);

    // One extra bit of headroom so the borrow lands in a dedicated sign bit.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted   = {prem, bit_in};
    assign diff      = shifted - {1'b0, dmag};
    assign q_bit     = ~diff[WIDTH+1];
    assign prem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/seq_signed_div.sv
// Multi-cycle signed divider: restoring shift-subtract on magnitudes,
// one quotient bit per clock, signs fixed up at the end.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : start/dividend/divisor in; busy/done/quotient/remainder/
//              div_by_zero/overflow out (seq_signed_div_if.slave)
// Results update only on the edge entering DONE and hold until the next
// operation reaches DONE.
module seq_signed_div
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    seq_signed_div_if.slave bus
);

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(min_val(WIDTH));

    state_t state, state_n;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dq;        // dividend bits out the top, quotient bits in the bottom
    logic [WIDTH:0]   prem;
    logic [WIDTH:0]   dmag;
    logic             sign_q;
    logic             sign_r;
    logic             ovf_pend;

    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;
    logic             ovf_r;

    logic [WIDTH:0]   step_prem;
    logic             step_q;

    logic             div_zero;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH:0]   dsr_abs;
    logic [WIDTH-1:0] q_neg;
    logic [WIDTH-1:0] r_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem),
        .bit_in    (dq[WIDTH-1]),
        .dmag      (dmag),
        .prem_next (step_prem),
        .q_bit     (step_q)
    );

    // |most-negative| = 2^(WIDTH-1) still fits WIDTH unsigned bits.
    always_comb begin
        div_zero = (bus.divisor == '0);
        dvd_abs  = WIDTH'(magnitude(wide_t'(bus.dividend), WIDTH));
        dsr_abs  = (WIDTH+1)'(magnitude(wide_t'(bus.divisor), WIDTH));
        q_neg    = WIDTH'(negate(wide_t'(dq), WIDTH));
        r_neg    = WIDTH'(negate(wide_t'(prem[WIDTH-1:0]), WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = div_zero ? DONE : CALC;
            CALC:    if (count == '0) state_n = FIX;
            FIX:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            dq          <= '0;
            prem        <= '0;
            dmag        <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            ovf_pend    <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (div_zero) begin
                            // Short-circuit straight to DONE with the defined result.
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                            ovf_r       <= 1'b0;
                        end else begin
                            dq       <= dvd_abs;
                            dmag     <= dsr_abs;
                            prem     <= '0;
                            count    <= CW'(WIDTH - 1);
                            sign_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            sign_r   <= bus.dividend[WIDTH-1];
                            ovf_pend <= (bus.dividend == MOST_NEG) && (bus.divisor == '1);
                        end
                    end
                end
                CALC: begin
                    prem <= step_prem;
                    dq   <= {dq[WIDTH-2:0], step_q};
                    if (count != '0) count <= count - 1'b1;
                end
                FIX: begin
                    // MOST_NEG / -1 gives magnitude 2^(WIDTH-1) with sign_q=0,
                    // which reads back as MOST_NEG: the defined wrap.
                    quotient_r  <= sign_q ? q_neg : dq;
                    remainder_r <= sign_r ? r_neg : prem[WIDTH-1:0];
                    dbz_r       <= 1'b0;
                    ovf_r       <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_seq_signed_div.sv
// Self-checking bench for seq_signed_div (WIDTH=8): directed corners,
// handshake/abort scenarios and a randomized sweep against an integer
// reference model built on the language's own / and % operators.
module tb_seq_signed_div;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 2;   // accept cycle 0 -> done cycle
    localparam int GAP   = WIDTH + 3;   // done-to-done with start held high
    localparam int MINV  = -(1 << (WIDTH - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_signed_div_if #(.WIDTH(WIDTH)) bus();

    seq_signed_div #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: truncating division, remainder follows dividend.
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r,
                                    output bit dz, output bit ov);
        dz = 0; ov = 0;
        if (b == 0) begin
            q = -1; r = a; dz = 1;
        end else if (a == MINV && b == -1) begin
            q = MINV; r = 0; ov = 1;   // +2^(W-1) wraps to most-negative
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    function automatic logic [2*WIDTH+1:0] snap();
        return {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow};
    endfunction

    // Starts one op from IDLE (called #1 after a posedge) and checks it.
    task automatic run_op(input int a, input int b);
        int q, r, cyc;
        bit dz, ov, busy_ok, hold_ok;
        logic [2*WIDTH+1:0] prev;
        string id;
        id = $sformatf("%0d/%0d", a, b);
        ref_div(a, b, q, r, dz, ov);
        prev = snap();
        bus.dividend = WIDTH'(a);
        bus.divisor  = WIDTH'(b);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = WIDTH'($urandom);
        bus.divisor  = WIDTH'($urandom);
        cyc = 1; busy_ok = 1; hold_ok = 1;
        while (!bus.done && cyc < 4 * LAT) begin
            if (!bus.busy) busy_ok = 0;
            if (snap() !== prev) hold_ok = 0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({"done_seen ", id}, bus.done, 1);
        chk({"latency ", id}, cyc, (b == 0) ? 1 : LAT);
        chk({"busy_hi ", id}, busy_ok && bus.busy, 1);
        chk({"hold ", id}, hold_ok, 1);
        chk({"quot ", id}, $signed(bus.quotient), q);
        chk({"rem ", id}, $signed(bus.remainder), r);
        chk({"dbz ", id}, bus.div_by_zero, dz);
        chk({"ovf ", id}, bus.overflow, ov);
        @(posedge clk); #1;
        chk({"busy_lo ", id}, bus.busy, 0);
        chk({"done_pulse ", id}, bus.done, 0);
    endtask

    int da[14] = '{100, -100, 100, -100, -128, -128, 5, 9, 0, 0, 127, -1, -128, 7};
    int db[14] = '{  7,    7,  -7,   -7,   -1,    1, 0, 3, 5, -3, -128, -128, -128, -1};
    int corner[6] = '{0, 1, -1, -128, 127, -127};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone, last, dn, a, b;
        bit gap_ok;
        logic signed [WIDTH-1:0] ra, rb;

        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_quot", bus.quotient, 0);
        chk("rst_rem", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        chk("rst_ovf", bus.overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_op(da[i], db[i]);

        // Stray starts during CALC (cycle 3) and DONE (cycle 10) are dropped.
        bus.dividend = 8'd100; bus.divisor = 8'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int c = 1; c < 26; c++) begin
            if (bus.done) ndone++;
            if (c == 3)  begin bus.start = 1'b1; bus.dividend = 8'hFB; bus.divisor = 8'd2; end
            if (c == 4)  bus.start = 1'b0;
            if (c == 10) bus.start = 1'b1;
            if (c == 11) bus.start = 1'b0;
            @(posedge clk); #1;
        end
        chk("ignore_done_count", ndone, 1);
        chk("ignore_quot", $signed(bus.quotient), 14);
        chk("ignore_rem", $signed(bus.remainder), 2);

        // Start held high: back-to-back ops.
        bus.dividend = 8'd100; bus.divisor = 8'd7; bus.start = 1'b1;
        ndone = 0; last = -1; gap_ok = 1;
        for (int c = 0; c < 4 * GAP + 2; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                if (last >= 0 && c - last != GAP) gap_ok = 0;
                last = c;
                ndone++;
            end
        end
        bus.start = 1'b0;
        chk("b2b_count", ndone, 4);
        chk("b2b_gap", gap_ok, 1);
        for (int c = 0; c < 4 * LAT && bus.busy; c++) begin
            @(posedge clk); #1;
        end
        chk("drain", bus.busy, 0);
        chk("b2b_quot", $signed(bus.quotient), 14);

        // Abort mid-CALC with asynchronous reset.
        bus.dividend = 8'd100; bus.divisor = 8'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_quot", bus.quotient, 0);
        chk("abort_rem", bus.remainder, 0);
        chk("abort_dbz", bus.div_by_zero, 0);
        chk("abort_ovf", bus.overflow, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        dn = 0;
        repeat (LAT + 2) begin
            @(posedge clk); #1;
            if (bus.done) dn++;
        end
        chk("abort_no_done", dn, 0);
        run_op(-7, 2);

        // Randomized sweep with a bias toward corner operands.
        for (int i = 0; i < 3000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            a = ra; b = rb;
            if ($urandom_range(0, 7) == 0) a = corner[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) b = corner[$urandom_range(0, 5)];
            run_op(a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
